// File: rtl/conf_slave_regbank.sv
// AXI4-Lite configuration register bank with per-slot read-only status words.
// One outstanding write, one read every two cycles; parallel register outputs.
module conf_slave_regbank #(
    parameter int unsigned NumRegs_Gen       = 8,
    parameter logic [31:0] BaseAddr_Gen      = 32'h0000_0000,
    parameter logic [63:0] ReadOnlyMask_Gen  = 64'h0,
    parameter logic [31:0] RegResetValue_Gen = 32'h0
) (
    input  logic                        SysClk_ClkIn,
    input  logic                        SysRstN_RstIn,
    input  logic                        AxiWriteAddrValid_ValIn,
    output logic                        AxiWriteAddrReady_RdyOut,
    input  logic [31:0]                 AxiWriteAddrAddress_AdrIn,
    input  logic [2:0]                  AxiWriteAddrProt_DatIn,
    input  logic                        AxiWriteDataValid_ValIn,
    output logic                        AxiWriteDataReady_RdyOut,
    input  logic [31:0]                 AxiWriteDataData_DatIn,
    input  logic [3:0]                  AxiWriteDataStrobe_DatIn,
    output logic                        AxiWriteRespValid_ValOut,
    input  logic                        AxiWriteRespReady_RdyIn,
    output logic [1:0]                  AxiWriteRespResponse_DatOut,
    input  logic                        AxiReadAddrValid_ValIn,
    output logic                        AxiReadAddrReady_RdyOut,
    input  logic [31:0]                 AxiReadAddrAddress_AdrIn,
    input  logic [2:0]                  AxiReadAddrProt_DatIn,
    output logic                        AxiReadDataValid_ValOut,
    input  logic                        AxiReadDataReady_RdyIn,
    output logic [1:0]                  AxiReadDataResponse_DatOut,
    output logic [31:0]                 AxiReadDataData_DatOut,
    output logic [32*NumRegs_Gen-1:0]   Reg_DatOut,
    output logic [NumRegs_Gen-1:0]      RegWritten_ValOut,
    input  logic [32*NumRegs_Gen-1:0]   Status_DatIn
);

    localparam int unsigned IdxW = (NumRegs_Gen > 1) ? $clog2(NumRegs_Gen) : 1;
    localparam logic [NumRegs_Gen-1:0] RoMask = ReadOnlyMask_Gen[NumRegs_Gen-1:0];

    logic [31:0]            regs_q [NumRegs_Gen];
    logic [31:0]            status_w [NumRegs_Gen];

    logic                   awready_q, wready_q, arready_q;
    logic                   aw_full_q, w_full_q;
    logic [IdxW-1:0]        aw_idx_q;
    logic                   aw_bad_q;
    logic [31:0]            w_data_q;
    logic [3:0]             w_strb_q;
    logic                   bvalid_q, rvalid_q;
    logic [1:0]             bresp_q, rresp_q;
    logic [31:0]            rdata_q;
    logic [NumRegs_Gen-1:0] regwritten_q;

    logic                   aw_full_d, w_full_d, bvalid_d, rvalid_d;

    logic [31:0]            aw_off_w, ar_off_w;
    logic                   aw_err_w, ar_err_w;
    logic [IdxW-1:0]        aw_idx_w, ar_idx_w;
    logic                   aw_bad_w, ar_ro_w;
    logic                   aw_hs_w, w_hs_w, b_hs_w, ar_hs_w, r_hs_w;
    logic                   commit_w, wr_ok_w;
    logic                   unused_w;

    // Below-base addresses wrap to huge offsets; the explicit compare catches them.
    assign aw_off_w = AxiWriteAddrAddress_AdrIn - BaseAddr_Gen;
    assign ar_off_w = AxiReadAddrAddress_AdrIn - BaseAddr_Gen;
    assign aw_err_w = (AxiWriteAddrAddress_AdrIn < BaseAddr_Gen) ||
                      ({2'b00, aw_off_w[31:2]} >= NumRegs_Gen);
    assign ar_err_w = (AxiReadAddrAddress_AdrIn < BaseAddr_Gen) ||
                      ({2'b00, ar_off_w[31:2]} >= NumRegs_Gen);
    assign aw_idx_w = aw_off_w[IdxW+1:2];
    assign ar_idx_w = ar_off_w[IdxW+1:2];
    assign aw_bad_w = aw_err_w || RoMask[aw_idx_w];
    assign ar_ro_w  = RoMask[ar_idx_w];

    assign unused_w = ^{aw_off_w[1:0], ar_off_w[1:0],
                        AxiWriteAddrProt_DatIn, AxiReadAddrProt_DatIn};

    assign aw_hs_w  = AxiWriteAddrValid_ValIn && awready_q;
    assign w_hs_w   = AxiWriteDataValid_ValIn && wready_q;
    assign b_hs_w   = bvalid_q && AxiWriteRespReady_RdyIn;
    assign ar_hs_w  = AxiReadAddrValid_ValIn && arready_q;
    assign r_hs_w   = rvalid_q && AxiReadDataReady_RdyIn;
    assign commit_w = aw_full_q && w_full_q;
    assign wr_ok_w  = commit_w && !aw_bad_q;

    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        if (aw_hs_w)  aw_full_d = 1'b1;
        if (w_hs_w)   w_full_d  = 1'b1;
        if (b_hs_w)   bvalid_d  = 1'b0;
        if (commit_w) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
        end
        if (r_hs_w)   rvalid_d  = 1'b0;
        if (ar_hs_w)  rvalid_d  = 1'b1;
    end

    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            arready_q    <= 1'b0;
            aw_full_q    <= 1'b0;
            w_full_q     <= 1'b0;
            aw_idx_q     <= '0;
            aw_bad_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            rvalid_q     <= 1'b0;
            rresp_q      <= 2'b00;
            rdata_q      <= '0;
            regwritten_q <= '0;
            for (int i = 0; i < NumRegs_Gen; i++) begin
                regs_q[i] <= RegResetValue_Gen;
            end
        end else begin
            awready_q <= !aw_full_d && !bvalid_d;
            wready_q  <= !w_full_d && !bvalid_d;
            arready_q <= !rvalid_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;

            if (aw_hs_w) begin
                aw_idx_q <= aw_idx_w;
                aw_bad_q <= aw_bad_w;
            end
            if (w_hs_w) begin
                w_data_q <= AxiWriteDataData_DatIn;
                w_strb_q <= AxiWriteDataStrobe_DatIn;
            end
            if (commit_w) begin
                bresp_q <= aw_bad_q ? 2'b10 : 2'b00;
            end

            regwritten_q <= '0;
            if (wr_ok_w) begin
                regwritten_q[aw_idx_q] <= 1'b1;
                for (int j = 0; j < 4; j++) begin
                    if (w_strb_q[j]) begin
                        regs_q[aw_idx_q][8*j +: 8] <= w_data_q[8*j +: 8];
                    end
                end
            end

            // Reads sample pre-edge state, so a same-edge commit is not visible.
            if (ar_hs_w) begin
                rresp_q <= ar_err_w ? 2'b10 : 2'b00;
                if (ar_err_w) begin
                    rdata_q <= '0;
                end else if (ar_ro_w) begin
                    rdata_q <= status_w[ar_idx_w];
                end else begin
                    rdata_q <= regs_q[ar_idx_w];
                end
            end
        end
    end

    for (genvar g = 0; g < NumRegs_Gen; g++) begin : g_slot
        assign status_w[g] = Status_DatIn[32*g +: 32];
        assign Reg_DatOut[32*g +: 32] = RoMask[g] ? 32'h0 : regs_q[g];
    end

    assign AxiWriteAddrReady_RdyOut    = awready_q;
    assign AxiWriteDataReady_RdyOut    = wready_q;
    assign AxiWriteRespValid_ValOut    = bvalid_q;
    assign AxiWriteRespResponse_DatOut = bresp_q;
    assign AxiReadAddrReady_RdyOut     = arready_q;
    assign AxiReadDataValid_ValOut     = rvalid_q;
    assign AxiReadDataResponse_DatOut  = rresp_q;
    assign AxiReadDataData_DatOut      = rdata_q;
    assign RegWritten_ValOut           = regwritten_q;

endmodule

// File: tb/tb_conf_slave_regbank.sv
// Directed bench for conf_slave_regbank: vector table plus corner sequences.
// Expected values are hand-computed constants.
module tb_conf_slave_regbank;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] RV   = 32'hCAFE_0001;
    localparam logic [31:0] ST7  = 32'h5A5A_0007;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              awvalid, awready, wvalid, wready;
    logic              bvalid, bready, arvalid, arready;
    logic              rvalid, rready;
    logic [31:0]       awaddr, wdata, araddr, rdata;
    logic [2:0]        awprot, arprot;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic [32*N-1:0]   reg_dat, status;
    logic [N-1:0]      reg_wr;

    int errors = 0;
    int checks = 0;
    int pcnt [N];
    int ptotal = 0;

    always #5 clk = ~clk;

    conf_slave_regbank #(
        .NumRegs_Gen       (N),
        .BaseAddr_Gen      (BASE),
        .ReadOnlyMask_Gen  (64'h80),
        .RegResetValue_Gen (RV)
    ) dut (
        .SysClk_ClkIn                (clk),
        .SysRstN_RstIn               (rst_n),
        .AxiWriteAddrValid_ValIn     (awvalid),
        .AxiWriteAddrReady_RdyOut    (awready),
        .AxiWriteAddrAddress_AdrIn   (awaddr),
        .AxiWriteAddrProt_DatIn      (awprot),
        .AxiWriteDataValid_ValIn     (wvalid),
        .AxiWriteDataReady_RdyOut    (wready),
        .AxiWriteDataData_DatIn      (wdata),
        .AxiWriteDataStrobe_DatIn    (wstrb),
        .AxiWriteRespValid_ValOut    (bvalid),
        .AxiWriteRespReady_RdyIn     (bready),
        .AxiWriteRespResponse_DatOut (bresp),
        .AxiReadAddrValid_ValIn      (arvalid),
        .AxiReadAddrReady_RdyOut     (arready),
        .AxiReadAddrAddress_AdrIn    (araddr),
        .AxiReadAddrProt_DatIn       (arprot),
        .AxiReadDataValid_ValOut     (rvalid),
        .AxiReadDataReady_RdyIn      (rready),
        .AxiReadDataResponse_DatOut  (rresp),
        .AxiReadDataData_DatOut      (rdata),
        .Reg_DatOut                  (reg_dat),
        .RegWritten_ValOut           (reg_wr),
        .Status_DatIn                (status)
    );

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reg_wr[i]) begin
                pcnt[i]++;
                ptotal++;
            end
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        logic [1:0]  resp;
        logic [31:0] rdat;
        int          pidx;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] d,
                                logic [3:0] s, int ld, logic [1:0] r,
                                logic [31:0] rd, int p);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.lead = ld;
        v.resp = r; v.rdat = rd; v.pidx = p;
        return v;
    endfunction

    function automatic logic [31:0] regw(int i);
        return reg_dat[32*i +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lead,
                            output logic [1:0] resp);
        int  cyc = 0;
        int  aw_st = (lead < 0) ? -lead : 0;
        int  w_st = (lead > 0) ? lead : 0;
        bit  aw_done = 0, w_done = 0, aw_f, w_f, got = 0;
        awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
        if (aw_st == 0) awvalid = 1'b1;
        if (w_st == 0) wvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            aw_f = awvalid && awready;
            w_f = wvalid && wready;
            @(posedge clk); #1;
            if (aw_f) begin awvalid = 1'b0; aw_done = 1; end
            if (w_f) begin wvalid = 1'b0; w_done = 1; end
            cyc++;
            if (!aw_done && cyc == aw_st) awvalid = 1'b1;
            if (!w_done && cyc == w_st) wvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        resp = 2'bxx;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bvalid) begin
                resp = bresp;
                got = 1;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL write_timeout: addr %h got no B response", a);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [1:0] resp,
                           output logic [31:0] dat);
        bit fired = 0, got = 0;
        araddr = a; rready = 1'b1; arvalid = 1'b1;
        for (int k = 0; k < 20 && !fired; k++) begin
            @(negedge clk);
            fired = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        resp = 2'bxx; dat = 'x;
        for (int k = 0; k < 20 && fired && !got; k++) begin
            @(negedge clk);
            if (rvalid) begin
                resp = rresp; dat = rdata; got = 1;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL read_timeout: addr %h got no R response", a);
        end
    endtask

    logic [1:0]  r2;
    logic [31:0] d32;
    int          pt0, pi0, seen;
    bit          bseen;

    initial begin
        rst_n = 1'b0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        awprot = 0; arprot = 0;
        for (int i = 0; i < N; i++) status[32*i +: 32] = 32'hFFFF_0000 | i;
        status[32*7 +: 32] = ST7;
        for (int i = 0; i < N; i++) pcnt[i] = 0;

        for (int i = 0; i < N; i++)
            tbl.push_back(mk(0, BASE + 4*i, 0, 0, 0, 2'b00,
                             (i == 7) ? ST7 : RV, -1));
        tbl.push_back(mk(1, BASE + 8, 32'hDEADBEEF, 4'hF, 3, 2'b00, 0, 2));
        tbl.push_back(mk(0, BASE + 8, 0, 0, 0, 2'b00, 32'hDEADBEEF, -1));
        tbl.push_back(mk(1, BASE + 8, 32'h11223344, 4'b0101, 0, 2'b00, 0, 2));
        tbl.push_back(mk(0, BASE + 8, 0, 0, 0, 2'b00, 32'hDE22BE44, -1));
        tbl.push_back(mk(1, BASE + 32, 32'h77, 4'hF, 0, 2'b10, 0, -1));
        tbl.push_back(mk(0, BASE + 32, 0, 0, 0, 2'b10, 32'h0, -1));
        tbl.push_back(mk(1, BASE - 4, 32'h88, 4'hF, 1, 2'b10, 0, -1));
        tbl.push_back(mk(0, BASE - 4, 0, 0, 0, 2'b10, 32'h0, -1));
        tbl.push_back(mk(1, BASE + 28, 32'h12345678, 4'hF, 0, 2'b10, 0, -1));
        tbl.push_back(mk(0, BASE + 28, 0, 0, 0, 2'b00, ST7, -1));
        tbl.push_back(mk(1, BASE + 4, 32'hFFFFFFFF, 4'h0, 0, 2'b00, 0, 1));
        tbl.push_back(mk(0, BASE + 4, 0, 0, 0, 2'b00, RV, -1));
        tbl.push_back(mk(1, BASE + 27, 32'h66, 4'hF, 0, 2'b00, 0, 6));
        tbl.push_back(mk(0, BASE + 24, 0, 0, 0, 2'b00, 32'h66, -1));
        tbl.push_back(mk(1, BASE, 32'hA0B0C0D0, 4'b1000, -2, 2'b00, 0, 0));
        tbl.push_back(mk(0, BASE, 0, 0, 0, 2'b00, 32'hA0FE0001, -1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vld_rdy", {29'd0, awready, wready, arready},
            32'd0);
        chk("reset_b_r", {28'd0, bvalid, rvalid, bresp | rresp}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_regwr", {24'd0, reg_wr}, 32'd0);
        chk("reset_reg0", regw(0), RV);
        chk("reset_reg7_ro", regw(7), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("readies_after_rst", {29'd0, awready, wready, arready}, 32'd7);
        @(posedge clk); #1;

        foreach (tbl[n]) begin
            if (tbl[n].wr) begin
                pt0 = ptotal;
                pi0 = (tbl[n].pidx >= 0) ? pcnt[tbl[n].pidx] : 0;
                do_write(tbl[n].addr, tbl[n].data, tbl[n].strb,
                         tbl[n].lead, r2);
                chk($sformatf("v%0d_bresp", n), {30'd0, r2},
                    {30'd0, tbl[n].resp});
                chk($sformatf("v%0d_pulses", n), ptotal - pt0,
                    (tbl[n].pidx >= 0) ? 1 : 0);
                if (tbl[n].pidx >= 0)
                    chk($sformatf("v%0d_pulse_idx", n),
                        pcnt[tbl[n].pidx] - pi0, 1);
            end else begin
                do_read(tbl[n].addr, r2, d32);
                chk($sformatf("v%0d_rresp", n), {30'd0, r2},
                    {30'd0, tbl[n].resp});
                chk($sformatf("v%0d_rdata", n), d32, tbl[n].rdat);
            end
        end

        chk("out_reg0", regw(0), 32'hA0FE0001);
        chk("out_reg1", regw(1), RV);
        chk("out_reg2", regw(2), 32'hDE22BE44);
        chk("out_reg6", regw(6), 32'h66);
        chk("out_reg7", regw(7), 32'h0);

        // BREADY held low: response and readies must freeze
        bready = 1'b0;
        awaddr = BASE + 12; wdata = 32'h33; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        bseen = 0;
        for (int k = 0; k < 10 && !bseen; k++) begin
            @(negedge clk);
            bseen = bvalid;
            if (!bseen) begin @(posedge clk); #1; end
        end
        chk("hold_bvalid_seen", {31'd0, bseen}, 32'd1);
        @(posedge clk); #1;
        awaddr = BASE + 16; awvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("hold_c%0d", k),
                {27'd0, bvalid, awready, wready, bresp}, 32'b10000);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        chk("after_b_hs", {30'd0, bvalid, awready}, 32'b01);
        @(posedge clk); #1;
        do_write(BASE + 16, 32'h44, 4'hF, 0, r2);
        chk("second_aw_bresp", {30'd0, r2}, 32'd0);
        chk("out_reg3", regw(3), 32'h33);
        chk("out_reg4", regw(4), 32'h44);

        // read and write commit on the same edge to register 1
        do_write(BASE + 4, 32'h0, 4'hF, 0, r2);
        awaddr = BASE + 4; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("same_edge_rdy", {30'd0, awready, wready}, 32'b11);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = BASE + 4; arvalid = 1'b1;
        @(negedge clk);
        chk("same_edge_arready", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("same_edge_valids", {30'd0, rvalid, bvalid}, 32'b11);
        chk("same_edge_old", rdata, 32'h0);
        @(posedge clk); #1;
        do_read(BASE + 4, r2, d32);
        chk("same_edge_new", d32, 32'h5);

        // reset with AW buffered and R pending
        rready = 1'b0;
        awaddr = BASE + 8; awvalid = 1'b1;
        araddr = BASE + 8; arvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {27'd0, awready, wready, arready, bvalid, rvalid},
            32'd0);
        chk("mid_rst_reg2", regw(2), RV);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rready = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bvalid || rvalid) seen++;
        end
        chk("no_stray_resp", seen, 0);
        @(posedge clk); #1;
        pt0 = ptotal; pi0 = pcnt[5];
        do_write(BASE + 20, 32'h55, 4'hF, 0, r2);
        chk("post_rst_bresp", {30'd0, r2}, 32'd0);
        chk("post_rst_pulse5", pcnt[5] - pi0, 1);
        chk("post_rst_pulses", ptotal - pt0, 1);
        do_read(BASE + 8, r2, d32);
        chk("post_rst_reg2", d32, RV);
        chk("post_rst_reg5", regw(5), 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/conf_slave_regbank.md
Name: conf_slave_regbank

Overview:
- AXI4-Lite responder: a bank of 32-bit configuration registers written and read over m_axi-style AXI4-Lite.
- Other end of the configuration master's bus. Lets the boot-time configuration sequence and later CPU accesses program a core's control registers.
- Exposes register contents in parallel to the core and accepts read-only status words from it.

Parameters:
- NumRegs_Gen, 8, number of 32-bit registers (1..64). Register i is at BaseAddr_Gen + 4*i.
- BaseAddr_Gen, 32'h0000_0000, byte base address of register 0. Must be 4-byte aligned.
- ReadOnlyMask_Gen, 64'h0, bit i = 1 makes register i read-only. Reads of register i return Status_DatIn word i.
- RegResetValue_Gen, 32'h0, reset value of every writable register.

Ports:
- SysClk_ClkIn  in  1  system clock; all logic is rising-edge.
- SysRstN_RstIn  in  1  asynchronous active-low reset.
- AxiWriteAddrValid_ValIn  in  1  AWVALID
- AxiWriteAddrReady_RdyOut  out  1  AWREADY
- AxiWriteAddrAddress_AdrIn  in  32  AWADDR
- AxiWriteAddrProt_DatIn  in  3  AWPROT (ignored)
- AxiWriteDataValid_ValIn  in  1  WVALID
- AxiWriteDataReady_RdyOut  out  1  WREADY
- AxiWriteDataData_DatIn  in  32  WDATA
- AxiWriteDataStrobe_DatIn  in  4  WSTRB
- AxiWriteRespValid_ValOut  out  1  BVALID
- AxiWriteRespReady_RdyIn  in  1  BREADY
- AxiWriteRespResponse_DatOut  out  2  BRESP
- AxiReadAddrValid_ValIn  in  1  ARVALID
- AxiReadAddrReady_RdyOut  out  1  ARREADY
- AxiReadAddrAddress_AdrIn  in  32  ARADDR
- AxiReadAddrProt_DatIn  in  3  ARPROT (ignored)
- AxiReadDataValid_ValOut  out  1  RVALID
- AxiReadDataReady_RdyIn  in  1  RREADY
- AxiReadDataResponse_DatOut  out  2  RRESP
- AxiReadDataData_DatOut  out  32  RDATA
- Reg_DatOut  out  32*NumRegs_Gen  register i on bits [32i+31:32i]. Read-only slots drive 0.
- RegWritten_ValOut  out  NumRegs_Gen  one-cycle pulse per register on write commit.
- Status_DatIn  in  32*NumRegs_Gen  status words for read-only slots. Other slots are unused.

Behaviour:
- Reset (async assert, synchronous release): all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, RegWritten 0, writable registers = RegResetValue_Gen, AW/W buffers empty.
- Address decode:
  - offset = addr - BaseAddr_Gen; addr[1:0] ignored; index = offset[31:2].
  - Decode error if offset < 0 (unsigned wrap) or index >= NumRegs_Gen.
- Write channel, AW and W independent:
  - AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID. Both are registered and go high one cycle after reset release.
  - AW handshake latches the address and sets aw_full. W handshake latches data and strobe and sets w_full. Either order, or the same cycle, is allowed.
  - Commit on the first edge where aw_full && w_full:
    - For a writable, in-range register, byte j is updated iff WSTRB[j]. RegWritten[i] pulses in the cycle after the commit edge, even if WSTRB = 0.
    - BVALID = 1 and both buffers are cleared.
    - BRESP: 2'b00 OKAY; 2'b10 SLVERR if out of range or read-only (no update, no pulse).
  - BVALID, BRESP and the buffers are held until BREADY. Then BVALID = 0 and READYs re-open next cycle.
  - A simple two-flag design is acceptable: at most one outstanding write.
- Read channel:
  - ARREADY = !RVALID.
  - On AR handshake at edge k: RVALID = 1 at edge k, with RDATA/RRESP registered from the register value present before edge k.
  - RRESP: OKAY in range (read-only slot returns Status_DatIn word). SLVERR out of range, RDATA = 0.
  - Held until RREADY. Read latency is 1 cycle with ARREADY high. Throughput is one read per 2 cycles.
- Simultaneous events:
  - A read and a write commit to the same register on the same edge: the read returns the old value.
  - Read and write channels operate fully concurrently.
- Reset mid-transaction: all pending AW/W/B/R state is discarded and registers are reinitialised. No response is issued for the aborted transfer.
- Stable outputs: RDATA/BRESP/RRESP change only when the corresponding VALID is low or a handshake completes.

Test Plan:
- After reset, read all NumRegs addresses -> RRESP 00, RDATA = RegResetValue_Gen (or Status_DatIn for RO slots). Reg_DatOut all reset value.
- AW addr Base+8 presented 3 cycles before W data 32'hDEADBEEF, WSTRB 4'hF -> single BVALID with BRESP 00, RegWritten[2] pulses once, register 2 = DEADBEEF. Then WSTRB 4'b0101 with 32'h11223344 -> register 2 = DE22BE44.
- AW and W same cycle to Base+4*NumRegs_Gen -> BRESP 10, no register change, no pulse. ARADDR same -> RRESP 10, RDATA 0.
- BREADY held low 10 cycles -> BVALID, BRESP stable; AWREADY/WREADY stay 0; a second AW is not accepted until after the B handshake.
- Read register 1 on the same edge a write of 32'h5 to register 1 commits (old 32'h0) -> RDATA 0, next read returns 5. Write to read-only slot -> BRESP 10.
- Assert reset with AW buffered and RVALID pending -> all VALIDs 0 immediately, registers reset, no stray B/R after release.
